sprite_line_scanner: RTL and testbench

- Per-scanline sequencer for the sprite attribute BRAM in the clk_draw domain.
- On each line start it walks sprite indices 0..NUM_SPRITES-1 through the BRAM read port, one per cycle, fully pipelined.
- It tests every entry's y/height against the current line and writes matching sprites into a line-list memory for the sprite fetch stage.
- It reports hit count, overflow and completion.

---
 rtl/sprite_line_scanner.sv | 76 +++++++
 tb/tb_sprite_line_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: walks the sprite attribute BRAM once per scanline and
// writes every sprite covering the line into the line-list memory.
module sprite_line_scanner #(
   parameter int NUM_SPRITES = 512,
   parameter int MAX_HITS    = 32,
   parameter int HA_W        = $clog2(MAX_HITS)
) (
   input  logic            clk_draw,
   input  logic            rst,
   input  logic            line_start,
   input  logic [15:0]     line_num,
   output logic [8:0]      sprite_index,
   input  logic [35:0]     sprite_y_height,
   output logic            hit_we,
   output logic [HA_W-1:0] hit_addr,
   output logic [8:0]      hit_sprite,
   output logic [15:0]     hit_row,
   output logic            busy,
   output logic            done,
   output logic [HA_W:0]   hit_count,
   output logic            overflow
);
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   localparam logic [8:0] LAST = 9'(NUM_SPRITES - 1);
   state_t state, state_nx;
   logic valid, hit, full, ovf_hit, unused_bits;
   logic [8:0] eval_idx;
   logic [15:0] line_q, rel;
   assign unused_bits = ^sprite_y_height[35:33];
   // lines above the sprite top wrap to large values and miss
   assign rel = line_q - sprite_y_height[15:0];
   assign hit = valid && sprite_y_height[32] && (rel < sprite_y_height[31:16]);
   assign full = hit_count[HA_W];
   assign ovf_hit = hit && full;
   assign busy = state != IDLE;
   always_ff @(posedge clk_draw or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = line_start ? SCAN :
                 state == SCAN  ? (ovf_hit ? DONE : sprite_index == LAST ? DRAIN : SCAN) :
                 state == DRAIN ? DONE : IDLE;
   end
   always_ff @(posedge clk_draw or posedge rst)
      if (rst) begin
         sprite_index <= '0;
         eval_idx     <= '0;
         valid        <= 1'b0;
         line_q       <= '0;
         hit_we       <= 1'b0;
         hit_addr     <= '0;
         hit_sprite   <= '0;
         hit_row      <= '0;
         hit_count    <= '0;
         overflow     <= 1'b0;
         done         <= 1'b0;
      end else begin
         done         <= state == DONE;
         valid        <= state == SCAN && !ovf_hit && !line_start;
         eval_idx     <= sprite_index;
         sprite_index <= (state_nx == SCAN && !line_start) ? sprite_index + 1'b1 : 9'd0;
         hit_we       <= hit && !full && !line_start;
         if (line_start) begin
            line_q    <= line_num;
            hit_count <= '0;
            overflow  <= 1'b0;
         end else if (hit && !full) begin
            hit_addr   <= hit_count[HA_W-1:0];
            hit_sprite <= eval_idx;
            hit_row    <= rel;
            hit_count  <= hit_count + 1'b1;
         end else if (ovf_hit) begin
            overflow <= 1'b1;
         end
      end
endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb_sprite_line_scanner: randomized scans of a modelled attribute BRAM,
// checked against a list-based reference of which sprites cover each line.
module tb_sprite_line_scanner;
   localparam int N = 512, MH = 32;
   logic clk_draw = 1'b0, rst = 1'b1, line_start = 1'b0;
   logic [15:0] line_num = '0;
   logic [8:0] sprite_index, hit_sprite;
   logic [35:0] sprite_y_height;
   logic hit_we, busy, done, overflow;
   logic [4:0] hit_addr;
   logic [15:0] hit_row;
   logic [5:0] hit_count;
   logic [35:0] mem [N];
   int vectors = 0, miscompares = 0;
   int exp_q[$];
   int exp_ovf;
   int got_cyc[$], got_addr[$], got_spr[$], got_row[$];

   sprite_line_scanner #(.NUM_SPRITES(N), .MAX_HITS(MH)) dut (
      .clk_draw(clk_draw), .rst(rst), .line_start(line_start), .line_num(line_num),
      .sprite_index(sprite_index), .sprite_y_height(sprite_y_height),
      .hit_we(hit_we), .hit_addr(hit_addr), .hit_sprite(hit_sprite), .hit_row(hit_row),
      .busy(busy), .done(done), .hit_count(hit_count), .overflow(overflow)
   );

   always #5 clk_draw = ~clk_draw;
   always @(posedge clk_draw) sprite_y_height <= mem[sprite_index];

   function automatic logic [35:0] attr(input int y, input int h, input bit en);
      logic [2:0] junk = 3'($urandom);
      return {junk, en, 16'(h), 16'(y)};
   endfunction

   task automatic clear_mem();
      for (int k = 0; k < N; k++) mem[k] = attr($urandom_range(0, 65535), $urandom_range(1, 300), 1'b0);
   endtask

   function automatic bit covers(input int k, input int l);
      int y = int'(mem[k][15:0]);
      int h = int'(mem[k][31:16]);
      int row = (l - y + 65536) % 65536;
      return mem[k][32] && row < h;
   endfunction

   function automatic void model(input int l);
      exp_q.delete();
      exp_ovf = -1;
      for (int k = 0; k < N; k++)
         if (covers(k, l)) begin
            if (exp_q.size() < MH) exp_q.push_back(k);
            else begin
               exp_ovf = k;
               break;
            end
         end
   endfunction

   task automatic start(input int l);
      @(negedge clk_draw);
      line_num = 16'(l);
      line_start = 1'b1;
      @(posedge clk_draw);
      #1 line_start = 1'b0;
   endtask

   task automatic run_scan(input int l);
      int done_cyc = -1, last_idx, exp_done, cnt_at_done = 0, ovf_at_done = 0, busy_at_done = 1;
      model(l);
      got_cyc.delete(); got_addr.delete(); got_spr.delete(); got_row.delete();
      last_idx = exp_ovf < 0 ? N - 1 : exp_ovf + 1;
      exp_done = exp_ovf < 0 ? N + 2 : exp_ovf + 3;
      start(l);
      for (int c = 0; c < 600 && done_cyc < 0; c++) begin
         @(negedge clk_draw);
         if (c == 0) begin
            vectors++;
            if (hit_count !== 0 || overflow !== 0 || busy !== 1 || hit_we !== 0) begin
               miscompares++;
               $display("FAIL start_state line=%0d: count=%0d ovf=%0d busy=%0d we=%0d, want 0 0 1 0", l, hit_count, overflow, busy, hit_we);
            end
         end
         if (c <= last_idx) begin
            vectors++;
            if (sprite_index !== 9'(c)) begin
               miscompares++;
               $display("FAIL sprite_index line=%0d cycle=%0d: got %0d, want %0d", l, c, sprite_index, c);
            end
         end
         if (hit_we === 1'b1) begin
            got_cyc.push_back(c); got_addr.push_back(int'(hit_addr));
            got_spr.push_back(int'(hit_sprite)); got_row.push_back(int'(hit_row));
         end
         if (done === 1'b1) begin
            done_cyc = c; cnt_at_done = int'(hit_count); ovf_at_done = int'(overflow); busy_at_done = int'(busy);
         end
      end
      vectors++;
      if (done_cyc != exp_done) begin
         miscompares++;
         $display("FAIL done_cycle line=%0d: got %0d, want %0d", l, done_cyc, exp_done);
      end
      vectors++;
      if (busy_at_done != 0 || cnt_at_done != exp_q.size() || ovf_at_done != int'(exp_ovf >= 0)) begin
         miscompares++;
         $display("FAIL final_status line=%0d: busy=%0d count=%0d ovf=%0d, want 0 %0d %0d",
                  l, busy_at_done, cnt_at_done, ovf_at_done, exp_q.size(), exp_ovf >= 0);
      end
      vectors++;
      if (got_cyc.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL write_count line=%0d: got %0d, want %0d", l, got_cyc.size(), exp_q.size());
      end
      for (int i = 0; i < got_cyc.size() && i < exp_q.size(); i++) begin
         int k = exp_q[i];
         int row = (l - int'(mem[k][15:0]) + 65536) % 65536;
         vectors++;
         if (got_cyc[i] != k + 2 || got_addr[i] != i || got_spr[i] != k || got_row[i] != row) begin
            miscompares++;
            $display("FAIL hit_write line=%0d #%0d: cyc=%0d addr=%0d spr=%0d row=%0d, want %0d %0d %0d %0d",
                     l, i, got_cyc[i], got_addr[i], got_spr[i], got_row[i], k + 2, i, k, row);
         end
      end
      @(negedge clk_draw);
      vectors++;
      if (done !== 1'b0 || hit_we !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse line=%0d: done=%0d we=%0d one cycle later, want 0 0", l, done, hit_we);
      end
   endtask

   task automatic check_zero(input string name);
      vectors++;
      if ({sprite_index, hit_we, hit_addr, hit_sprite, hit_row, busy, done, hit_count, overflow} !== '0) begin
         miscompares++;
         $display("FAIL %s: idx=%0d we=%0d addr=%0d spr=%0d row=%0d busy=%0d done=%0d count=%0d ovf=%0d, want all 0",
                  name, sprite_index, hit_we, hit_addr, hit_sprite, hit_row, busy, done, hit_count, overflow);
      end
   endtask

   task automatic test_reset();
      clear_mem();
      rst = 1'b1;
      repeat (3) @(posedge clk_draw);
      @(negedge clk_draw);
      check_zero("reset_state");
      rst = 1'b0;
   endtask

   task automatic test_basic();
      clear_mem();
      mem[5] = attr(100, 16, 1'b1);
      run_scan(107);
   endtask

   task automatic test_boundaries();
      int lines[4] = '{99, 100, 115, 116};
      clear_mem();
      mem[5] = attr(100, 16, 1'b1);
      foreach (lines[i]) run_scan(lines[i]);
      mem[5] = attr(100, 0, 1'b1);
      run_scan(100);
      mem[5] = attr(100, 16, 1'b0);
      run_scan(100);
      mem[511] = attr(65530, 10, 1'b1);
      run_scan(3);
   endtask

   task automatic test_exact_full();
      clear_mem();
      for (int k = 0; k < MH; k++) mem[k * 16 + int'($urandom_range(0, 15))] = attr(50 - int'($urandom_range(0, 10)), 11 + int'($urandom_range(0, 20)), 1'b1);
      run_scan(50);
   endtask

   task automatic test_overflow();
      clear_mem();
      for (int k = 0; k < 40; k++) mem[k] = attr(45, 10, 1'b1);
      run_scan(50);
   endtask

   task automatic test_back_to_back();
      clear_mem();
      for (int k = 0; k < 20; k++) mem[$urandom_range(0, N - 1)] = attr(200, 50, 1'b1);
      run_scan(210);
      run_scan(260);
   endtask

   task automatic test_abort();
      int old_hits = 0, dones = 0;
      clear_mem();
      mem[30]  = attr(0, 30, 1'b1);
      mem[50]  = attr(5, 10, 1'b1);
      mem[300] = attr(15, 10, 1'b1);
      start(10);
      for (int c = 0; c < 99; c++) begin
         @(negedge clk_draw);
         old_hits += int'(hit_we === 1'b1);
         dones += int'(done === 1'b1);
      end
      vectors++;
      if (old_hits != 2 || dones != 0) begin
         miscompares++;
         $display("FAIL abort_first_line: hits=%0d dones=%0d, want 2 0", old_hits, dones);
      end
      run_scan(20);
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      clear_mem();
      for (int k = 0; k < 10; k++) mem[k * 40] = attr(70, 20, 1'b1);
      start(75);
      repeat (200) @(posedge clk_draw);
      #2 rst = 1'b1;
      #1 check_zero("reset_mid_scan");
      repeat (3) begin
         @(negedge clk_draw);
         dones += int'(done === 1'b1);
      end
      rst = 1'b0;
      repeat (520) begin
         @(negedge clk_draw);
         dones += int'(done === 1'b1 || busy === 1'b1);
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("FAIL reset_no_done: done/busy cycles=%0d, want 0", dones);
      end
      run_scan(75);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int l = int'($urandom_range(0, 65535));
         int nh = int'($urandom_range(0, 45));
         clear_mem();
         for (int i = 0; i < nh; i++)
            mem[$urandom_range(0, N - 1)] = attr((l - int'($urandom_range(0, 24)) + 65536) % 65536,
                                                 $urandom_range(0, 30), $urandom_range(0, 7) != 0);
         run_scan(l);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_exact_full();
      test_overflow();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
